note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Plays a melody by stepping through an external song ROM, one entry per note.
- Each entry is decoded into a max_preset value for divider_12 plus a note duration in beats.
- Holds each note for its duration, then optionally inserts a short silent articulation gap.
- Sits between the song ROM and divider_12; tone_en gates clk_div onto the speaker pin.

Parameters:
- ADDR_W, 6, song ROM address width; song length is at most 2^ADDR_W entries.
- BEAT_CYC, 25000, clk cycles per beat; must be at least 1.
- GAP_CYC, 1000, silent clk cycles after each note; 0 disables the gap.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins playback at address 0 when IDLE.
- stop  in  1  single-cycle pulse; aborts playback.
- rom_addr  out  ADDR_W  registered song ROM address.
- rom_data  in  8  ROM word, registered inside the ROM (1-cycle read latency). [7:4] note code, [3:0] dur.
- max_preset  out  8  preset driven to divider_12.max_preset.
- tone_en  out  1  high while a pitched note sounds.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the song ends normally.

Behaviour:
- Reset values: state IDLE, rom_addr 0, max_preset 0, tone_en 0, busy 0, done 0, counters 0. Reset is asynchronous and active-high on rst; asserting it mid-song returns to IDLE immediately.
- States: IDLE, FETCH, READ, PLAY, GAP.
- IDLE: when start=1, set rom_addr←0 and go to FETCH. stop is ignored here.
- FETCH: the ROM latches the word at rom_addr. Next state is READ.
- READ: decode rom_data.
  - note=15 (end marker): set tone_en←0, pulse done, go to IDLE.
  - note=0 (rest): set tone_en←0, leave max_preset unchanged.
  - note=1..14: set max_preset←table[note], tone_en←1.
  - For any note other than 15: load beat_cnt←dur, cyc_cnt←0, go to PLAY.
- Preset table: 1:238, 2:212, 3:189, 4:178, 5:159, 6:141, 7:126, 8:119, 9:106, 10:94, 11:89, 12:79, 13:70, 14:63.
- PLAY: cyc_cnt counts 0..BEAT_CYC-1. At wrap, if beat_cnt=0 the note ends; otherwise beat_cnt decrements.
  - A note lasts exactly (dur+1)*BEAT_CYC cycles of PLAY.
  - At note end: tone_en←0. If GAP_CYC>0, go to GAP; otherwise advance.
- GAP: lasts exactly GAP_CYC cycles with tone_en=0, then advance.
- Advance: rom_addr←rom_addr+1, go to FETCH.
  - If rom_addr = 2^ADDR_W-1, treat it as an end marker: pulse done, set rom_addr←0, go to IDLE.
- Latency: with start sampled on edge N, tone_en and max_preset update on edge N+2.
  - Note-to-note: PLAY/GAP end → FETCH → READ, so 2 cycles of tone_en=0 between notes beyond GAP_CYC.
- stop, in any non-IDLE state: on the next edge set state←IDLE, tone_en←0, busy←0, no done pulse. max_preset holds.
- start and stop in the same cycle: stop wins; from IDLE nothing happens.
- start while busy is ignored.
- busy is a registered output, high from the edge after start through the edge that returns to IDLE.
- max_preset changes only in READ and is stable for the whole of PLAY.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined: an end marker or address wrap sets rom_addr←0 and goes to FETCH without entering IDLE. done still pulses once per pass and busy stays high. Only stop or rst ends playback.
- Undefined: behaviour is as above; playback returns to IDLE at song end.

Test Plan:
- Test parameters for all scenarios: BEAT_CYC=4, GAP_CYC=2.
- ROM {0x10, 0x51, 0xF0}; start pulse → max_preset=238 and tone_en=1 for 4 cycles; tone_en=0 for 4 cycles (gap plus fetch); max_preset=159 and tone_en=1 for 8 cycles; done pulses once; busy falls; tone_en=0.
- ROM {0x02, 0x30, 0xF0} → tone_en=0 for 12 cycles with max_preset=0, then max_preset=189 for 4 cycles, then done.
- Pulse stop during the 2nd beat of note 0x51 → tone_en=0 and busy=0 on the next edge, no done pulse, max_preset stays 159. A start in the same cycle as this stop is ignored.
- Assert rst mid-PLAY → all outputs return to reset values asynchronously; a subsequent start replays from rom_addr 0.
- ADDR_W=2, ROM with no 0xF entry → after address 3 plays, done pulses and rom_addr returns to 0. With SEQ_LOOP_EN: address 0 replays, done pulses each pass, busy stays 1.
- Start pulse while busy → ignored; the note sequence and timing are unchanged.

Source files
------------

// File: rtl/note_sequencer.sv
// Song ROM walker: decodes {note, dur} words into a divider preset and holds each note.
// Optional SEQ_LOOP_EN: restart from address 0 at song end instead of returning to idle.
module note_sequencer #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned BEAT_CYC = 25000,
  parameter int unsigned GAP_CYC  = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic [7:0]        max_preset_o,
  output logic              tone_en_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CycW = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CycW-1:0]   CycLast  = CycW'(BEAT_CYC - 1);
  localparam logic [GapW-1:0]   GapLast  = (GAP_CYC > 0) ? GapW'(GAP_CYC - 1) : '0;
  localparam logic [ADDR_W-1:0] AddrLast = '1;

  typedef enum logic [2:0] {StIdle, StFetch, StRead, StPlay, StGap} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        preset_q, preset_d;
  logic              tone_q, tone_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        beat_q, beat_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              advance, song_end;

  logic [3:0] rom_note, rom_dur;
  assign rom_note = rom_data_i[7:4];
  assign rom_dur  = rom_data_i[3:0];

  function automatic logic [7:0] note_preset(input logic [3:0] note);
    case (note)
      4'd1:    note_preset = 8'd238;
      4'd2:    note_preset = 8'd212;
      4'd3:    note_preset = 8'd189;
      4'd4:    note_preset = 8'd178;
      4'd5:    note_preset = 8'd159;
      4'd6:    note_preset = 8'd141;
      4'd7:    note_preset = 8'd126;
      4'd8:    note_preset = 8'd119;
      4'd9:    note_preset = 8'd106;
      4'd10:   note_preset = 8'd94;
      4'd11:   note_preset = 8'd89;
      4'd12:   note_preset = 8'd79;
      4'd13:   note_preset = 8'd70;
      4'd14:   note_preset = 8'd63;
      default: note_preset = 8'd0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    preset_d = preset_q;
    tone_d   = tone_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    beat_d   = beat_q;
    cyc_d    = cyc_q;
    gap_d    = gap_q;
    advance  = 1'b0;
    song_end = 1'b0;

    // stop outranks everything else, including a simultaneous start or song end
    if (stop_i && (state_q != StIdle)) begin
      state_d = StIdle;
      tone_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && !stop_i) begin
            addr_d  = '0;
            busy_d  = 1'b1;
            state_d = StFetch;
          end
        end
        StFetch: state_d = StRead;
        StRead: begin
          if (rom_note == 4'hF) begin
            song_end = 1'b1;
          end else begin
            tone_d = (rom_note != 4'd0);
            if (rom_note != 4'd0) begin
              preset_d = note_preset(rom_note);
            end
            beat_d  = rom_dur;
            cyc_d   = '0;
            state_d = StPlay;
          end
        end
        StPlay: begin
          if (cyc_q == CycLast) begin
            cyc_d = '0;
            if (beat_q == 4'd0) begin
              tone_d = 1'b0;
              if (GAP_CYC > 0) begin
                gap_d   = '0;
                state_d = StGap;
              end else begin
                advance = 1'b1;
              end
            end else begin
              beat_d = beat_q - 4'd1;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            advance = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      // running off the top of the address space counts as an end marker
      if (advance) begin
        if (addr_q == AddrLast) begin
          song_end = 1'b1;
          addr_d   = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StFetch;
        end
      end

      if (song_end) begin
        done_d = 1'b1;
        tone_d = 1'b0;
`ifdef SEQ_LOOP_EN
        addr_d  = '0;
        state_d = StFetch;
`else
        busy_d  = 1'b0;
        state_d = StIdle;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      preset_q <= '0;
      tone_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      beat_q   <= '0;
      cyc_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      preset_q <= preset_d;
      tone_q   <= tone_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      beat_q   <= beat_d;
      cyc_q    <= cyc_d;
      gap_q    <= gap_d;
    end
  end

  assign rom_addr_o   = addr_q;
  assign max_preset_o = preset_q;
  assign tone_en_o    = tone_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
